// File: rtl/fb_pkg.sv
// Shared types and default geometry for the ping-pong frame buffer controller.
package fb_pkg;

  localparam int unsigned C_IMG_PXLS_DEF    = 4800;
  localparam int unsigned C_NB_IMG_PXLS_DEF = 13;
  localparam int unsigned C_NB_BUF_DEF      = 16;

  typedef enum logic [1:0] {
    S_CFG   = 2'd0,
    S_SYNC  = 2'd1,
    S_CAP   = 2'd2,
    S_READY = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_pingpong_ctrl_if.sv
// Capture-side inputs, buffer write port and display/status signals of the controller.
interface fb_pingpong_ctrl_if
  import fb_pkg::*;
#(
  parameter int unsigned C_NB_IMG_PXLS = C_NB_IMG_PXLS_DEF,
  parameter int unsigned C_NB_BUF      = C_NB_BUF_DEF
);

  logic                     config_done;
  logic                     freeze;
  logic                     cap_we;
  logic [C_NB_IMG_PXLS-1:0] cap_addr;
  logic [C_NB_BUF-1:0]      cap_data;
  logic                     disp_sof;
  logic                     wea0;
  logic                     wea1;
  logic [C_NB_IMG_PXLS-1:0] addra;
  logic [C_NB_BUF-1:0]      dina;
  logic                     rd_sel;
  logic                     frame_ready;
  logic [7:0]               frame_cnt;
  logic                     overrun;
  logic                     sof_err;

  modport master (
    output config_done, freeze, cap_we, cap_addr, cap_data, disp_sof,
    input  wea0, wea1, addra, dina, rd_sel, frame_ready, frame_cnt, overrun, sof_err
  );

  modport slave (
    input  config_done, freeze, cap_we, cap_addr, cap_data, disp_sof,
    output wea0, wea1, addra, dina, rd_sel, frame_ready, frame_cnt, overrun, sof_err
  );

endinterface

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: camera writes fill the back buffer,
// display start-of-frame swaps it to the front once a full frame is captured.
module fb_pingpong_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned C_IMG_PXLS    = C_IMG_PXLS_DEF,
  parameter int unsigned C_NB_IMG_PXLS = C_NB_IMG_PXLS_DEF,
  parameter int unsigned C_NB_BUF      = C_NB_BUF_DEF
) (
  input  logic                clk,
  input  logic                rst,
  fb_pingpong_ctrl_if.slave   bus
);

  localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_PXLS - 1);

  fb_state_t                state, state_nxt;
  logic                     wr, swap, ovr_nxt, serr_nxt;
  logic                     rd_sel_q;
  logic [7:0]               frame_cnt_q;
  logic                     wea0_q, wea1_q;
  logic [C_NB_IMG_PXLS-1:0] addra_q;
  logic [C_NB_BUF-1:0]      dina_q;
  logic                     frame_ready_q, overrun_q, sof_err_q;
  logic                     addr_zero, addr_in_range;

  assign addr_zero     = (bus.cap_addr == '0);
  assign addr_in_range = (32'(bus.cap_addr) < C_IMG_PXLS);

  // Losing config_done overrides everything; writes are blocked in that cycle too.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    swap      = 1'b0;
    ovr_nxt   = 1'b0;
    serr_nxt  = 1'b0;
    if (!bus.config_done) begin
      state_nxt = S_CFG;
    end else begin
      unique case (state)
        S_CFG:  state_nxt = S_SYNC;
        S_SYNC: begin
          if (bus.cap_we && addr_zero && !bus.freeze) begin
            wr        = 1'b1;
            state_nxt = S_CAP;
          end
        end
        S_CAP: begin
          if (bus.cap_we && addr_in_range) begin
            wr       = 1'b1;
            serr_nxt = addr_zero;
            if (bus.cap_addr == LAST_ADDR) state_nxt = S_READY;
          end
        end
        S_READY: begin
          if (bus.disp_sof) begin
            swap      = 1'b1;
            state_nxt = S_SYNC;
          end else if (bus.cap_we && addr_zero) begin
            ovr_nxt = 1'b1;
          end
        end
        default: state_nxt = S_CFG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_CFG;
      rd_sel_q      <= 1'b0;
      frame_cnt_q   <= '0;
      wea0_q        <= 1'b0;
      wea1_q        <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_ready_q <= (state_nxt == S_READY);
      overrun_q     <= ovr_nxt;
      sof_err_q     <= serr_nxt;
      // Back buffer is ~rd_sel; rd_sel never changes in a cycle that writes.
      wea0_q        <= wr & rd_sel_q;
      wea1_q        <= wr & ~rd_sel_q;
      if (wr) begin
        addra_q <= bus.cap_addr;
        dina_q  <= bus.cap_data;
      end
      if (swap) begin
        rd_sel_q    <= ~rd_sel_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.wea0        = wea0_q;
  assign bus.wea1        = wea1_q;
  assign bus.addra       = addra_q;
  assign bus.dina        = dina_q;
  assign bus.rd_sel      = rd_sel_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.sof_err     = sof_err_q;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed bench for fb_pingpong_ctrl: full frames, swap, overrun, sof_err, freeze, reset.
module tb_fb_pingpong_ctrl;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;
  int   w0, w1, both, front, dbad;

  fb_pingpong_ctrl_if #(.C_NB_IMG_PXLS(13), .C_NB_BUF(16)) bus ();

  fb_pingpong_ctrl #(
    .C_IMG_PXLS(4800),
    .C_NB_IMG_PXLS(13),
    .C_NB_BUF(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wea0) w0++;
    if (bus.wea1) w1++;
    if (bus.wea0 && bus.wea1) both++;
    if ((bus.wea0 && !bus.rd_sel) || (bus.wea1 && bus.rd_sel)) front++;
    if ((bus.wea0 || bus.wea1) && (bus.dina != 16'(bus.addra))) dbad++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic px(input int a);
    bus.cap_we   = 1'b1;
    bus.cap_addr = 13'(a);
    bus.cap_data = 16'(a);
    cyc();
    bus.cap_we   = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) px(a);
  endtask

  task automatic clr();
    w0 = 0; w1 = 0;
  endtask

  initial begin
    ntests = 0; nfail = 0;
    w0 = 0; w1 = 0; both = 0; front = 0; dbad = 0;
    rst = 1'b1;
    bus.config_done = 1'b0;
    bus.freeze      = 1'b0;
    bus.cap_we      = 1'b0;
    bus.cap_addr    = '0;
    bus.cap_data    = '0;
    bus.disp_sof    = 1'b0;
    repeat (3) cyc();

    chk("rst_rd_sel", 32'(bus.rd_sel), 0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
    chk("rst_frame_ready", 32'(bus.frame_ready), 0);
    chk("rst_wea", 32'({bus.wea0, bus.wea1}), 0);
    chk("rst_addra_dina", 32'({bus.addra, bus.dina}), 0);
    chk("rst_pulses", 32'({bus.overrun, bus.sof_err}), 0);

    // First frame into buffer 1
    rst = 1'b0;
    bus.config_done = 1'b1;
    cyc();
    clr();
    px(0);
    chk("f1_first_wea1", 32'(bus.wea1), 1);
    px(1);
    chk("f1_addr1_addra", 32'(bus.addra), 1);
    chk("f1_addr1_dina", 32'(bus.dina), 1);
    chk("f1_ready_early", 32'(bus.frame_ready), 0);
    run(2, 4799);
    chk("f1_ready_last", 32'(bus.frame_ready), 1);
    cyc();
    chk("f1_w1_count", 32'(w1), 4800);
    chk("f1_w0_count", 32'(w0), 0);
    chk("f1_frame_ready", 32'(bus.frame_ready), 1);

    // Overrun in S_READY
    clr();
    px(0);
    chk("ovr_pulse", 32'(bus.overrun), 1);
    chk("ovr_no_wea", 32'({bus.wea0, bus.wea1}), 0);
    cyc();
    chk("ovr_one_cycle", 32'(bus.overrun), 0);
    chk("ovr_frame_cnt", 32'(bus.frame_cnt), 0);
    chk("ovr_still_ready", 32'(bus.frame_ready), 1);
    chk("ovr_no_writes", 32'(w0 + w1), 0);

    // Swap
    bus.disp_sof = 1'b1;
    cyc();
    bus.disp_sof = 1'b0;
    chk("swap1_rd_sel", 32'(bus.rd_sel), 1);
    chk("swap1_frame_cnt", 32'(bus.frame_cnt), 1);
    chk("swap1_ready_clr", 32'(bus.frame_ready), 0);

    // Second frame into buffer 0, restart at 2000, final write meets disp_sof
    clr();
    run(0, 2000);
    px(0);
    chk("serr_pulse", 32'(bus.sof_err), 1);
    chk("serr_wea0", 32'(bus.wea0), 1);
    chk("serr_addra", 32'(bus.addra), 0);
    px(1);
    chk("serr_one_cycle", 32'(bus.sof_err), 0);
    chk("serr_still_cap", 32'(bus.wea0), 1);
    run(2, 4798);
    bus.disp_sof = 1'b1;
    px(4799);
    bus.disp_sof = 1'b0;
    chk("coinc_no_swap_sel", 32'(bus.rd_sel), 1);
    chk("coinc_no_swap_cnt", 32'(bus.frame_cnt), 1);
    chk("coinc_ready", 32'(bus.frame_ready), 1);
    cyc();
    chk("f2_w0_count", 32'(w0), 6801);
    chk("f2_w1_count", 32'(w1), 0);
    bus.disp_sof = 1'b1;
    cyc();
    bus.disp_sof = 1'b0;
    chk("swap2_rd_sel", 32'(bus.rd_sel), 0);
    chk("swap2_frame_cnt", 32'(bus.frame_cnt), 2);

    // disp_sof outside S_READY
    bus.disp_sof = 1'b1;
    cyc();
    bus.disp_sof = 1'b0;
    chk("sof_sync_rd_sel", 32'(bus.rd_sel), 0);
    chk("sof_sync_cnt", 32'(bus.frame_cnt), 2);

    // Freeze blocks a whole frame, then capture with out-of-range addresses and late freeze
    clr();
    bus.freeze = 1'b1;
    run(0, 4799);
    cyc();
    chk("frz_no_writes", 32'(w0 + w1), 0);
    chk("frz_not_ready", 32'(bus.frame_ready), 0);
    bus.freeze = 1'b0;
    run(0, 9);
    px(4800);
    chk("oor_4800_dropped", 32'({bus.wea0, bus.wea1}), 0);
    px(8191);
    chk("oor_8191_dropped", 32'({bus.wea0, bus.wea1}), 0);
    bus.freeze = 1'b1;
    run(10, 4799);
    cyc();
    bus.freeze = 1'b0;
    chk("frz_mid_w1", 32'(w1), 4800);
    chk("frz_mid_w0", 32'(w0), 0);
    chk("frz_mid_ready", 32'(bus.frame_ready), 1);

    // config_done falling returns to S_CFG, swap state retained
    bus.config_done = 1'b0;
    cyc();
    chk("cfg_drop_ready", 32'(bus.frame_ready), 0);
    chk("cfg_drop_rd_sel", 32'(bus.rd_sel), 0);
    chk("cfg_drop_cnt", 32'(bus.frame_cnt), 2);
    px(0);
    chk("cfg_blocks_write", 32'({bus.wea0, bus.wea1}), 0);
    bus.config_done = 1'b1;
    cyc();

    // Reset mid-capture
    run(0, 5);
    bus.cap_we   = 1'b1;
    bus.cap_addr = 13'd6;
    bus.cap_data = 16'd6;
    rst = 1'b1;
    cyc();
    bus.cap_addr = 13'd7;
    bus.cap_data = 16'd7;
    rst = 1'b0;
    cyc();
    bus.cap_we = 1'b0;
    chk("rst_mid_no_write", 32'({bus.wea0, bus.wea1}), 0);
    chk("rst_mid_addra", 32'(bus.addra), 0);
    chk("rst_mid_cnt", 32'(bus.frame_cnt), 0);
    chk("rst_mid_rd_sel", 32'(bus.rd_sel), 0);

    cyc();
    chk("never_both_wea", 32'(both), 0);
    chk("never_front_write", 32'(front), 0);
    chk("data_follows_addr", 32'(dbad), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fb_pingpong_ctrl.md
FB_PINGPONG_CTRL -- requirements
Module: fb_pingpong_ctrl

Interface
REQ-001 SHALL have parameter C_IMG_PXLS, default 4800, pixels per frame (80x60).
REQ-002 SHALL have parameter C_NB_IMG_PXLS, default 13, frame address width.
REQ-003 SHALL have parameter C_NB_BUF, default 16, pixel word width (RGB 5/5/6).
REQ-004 SHALL have port clk  in  1  system clock (50 MHz pixel/OLED domain); all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port config_done  in  1  camera register configuration finished (level).
REQ-007 SHALL have port freeze  in  1  stop starting new captures (level, button).
REQ-008 SHALL have port cap_we  in  1  capture write strobe, one cycle per pixel.
REQ-009 SHALL have port cap_addr  in  C_NB_IMG_PXLS  capture pixel address.
REQ-010 SHALL have port cap_data  in  C_NB_BUF  capture pixel data.
REQ-011 SHALL have port disp_sof  in  1  one-cycle pulse at start of a display frame.
REQ-012 SHALL have ports wea0, wea1  out  1 each  write enable for buffer 0 / buffer 1.
REQ-013 SHALL have ports addra  out  C_NB_IMG_PXLS, dina  out  C_NB_BUF  shared buffer write port.
REQ-014 SHALL have port rd_sel  out  1  buffer index the display reads (front buffer).
REQ-015 SHALL have port frame_ready  out  1  completed back frame awaiting swap.
REQ-016 SHALL have port frame_cnt  out  8  count of swaps performed.
REQ-017 SHALL have port overrun  out  1  one-cycle pulse: new camera frame began while frame_ready.
REQ-018 SHALL have port sof_err  out  1  one-cycle pulse: address 0 seen mid-capture.

Function
REQ-019 SHALL implement states S_CFG, S_SYNC, S_CAP, S_READY; back buffer = ~rd_sel.
REQ-020 S_CFG: all writes blocked; config_done=1 -> S_SYNC next cycle.
REQ-021 S_SYNC: writes blocked; cap_we & cap_addr==0 & freeze=0 -> S_CAP, and that write SHALL be forwarded.
REQ-022 S_CAP: every cap_we SHALL be forwarded to back buffer only; cap_we & cap_addr==C_IMG_PXLS-1 -> S_READY (write forwarded).
REQ-023 S_CAP: cap_we & cap_addr==0 SHALL pulse sof_err, stay S_CAP, forward the write (frame restarts).
REQ-024 freeze asserted during S_CAP SHALL NOT abort the current frame; it only blocks S_SYNC->S_CAP.
REQ-025 S_READY: writes blocked; disp_sof -> toggle rd_sel, frame_cnt+1 (wraps 255->0), -> S_SYNC.
REQ-026 S_READY: cap_we & cap_addr==0 without disp_sof SHALL pulse overrun; frame dropped; stay S_READY.
REQ-027 disp_sof in same cycle as final S_CAP write SHALL NOT swap; swap waits for next disp_sof.
REQ-028 disp_sof outside S_READY SHALL be ignored.
REQ-029 Write port SHALL be registered: wea*/addra/dina valid exactly 1 cycle after accepted cap_we.
REQ-030 wea0 and wea1 SHALL never both be 1; writes never target buffer rd_sel.
REQ-031 frame_ready SHALL equal (state==S_READY), registered.
REQ-032 config_done falling in any state SHALL return to S_CFG next cycle, rd_sel/frame_cnt retained.
REQ-033 cap_addr >= C_IMG_PXLS in S_CAP SHALL be dropped (no write).

Reset
REQ-034 On rst: state=S_CFG, rd_sel=0, frame_cnt=0, wea0=wea1=0, addra=0, dina=0, frame_ready=0, overrun=0, sof_err=0.
REQ-035 Reset mid-capture SHALL discard the partial frame; no write issued in the cycle after rst release.

Structure
REQ-036 State encoding, C_IMG_PXLS/C_NB_IMG_PXLS/C_NB_BUF defaults SHALL live in shared package fb_pkg.
REQ-037 Single module, no sub-modules; FSM plus one write-stage register bank.

Verification
REQ-038 Reset, config_done=1, write addr 0..4799 with data=addr -> wea1 pulses 4800 times (rd_sel=0), frame_ready=1 after last +1 cycle.
REQ-039 From S_READY pulse disp_sof -> rd_sel=1, frame_cnt=1, next frame writes via wea0 only.
REQ-040 In S_READY drive cap_we addr=0 -> overrun one-cycle pulse, no wea*, frame_cnt unchanged.
REQ-041 In S_CAP at addr 2000 drive addr=0 -> sof_err pulse, write to addr 0 forwarded, still S_CAP.
REQ-042 freeze=1 in S_SYNC, full frame presented -> zero writes; freeze=0 at next addr 0 -> capture starts.
REQ-043 Final write (addr 4799) coincident with disp_sof -> no swap; next disp_sof swaps, frame_cnt increments once.
